// File: rtl/draw_wburst.sv
// Write-burst master: one 8-beat AXI INCR write burst per command, fed by the
// drawing core's pixel stream, with sticky error and completed-burst counter.
module draw_wburst #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               CMD_VALID,
  output logic                               CMD_READY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      CMD_ADDR,
  input  logic                               PIX_VALID,
  output logic                               PIX_READY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      PIX_DATA,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  output logic                               BUSY,
  output logic                               DONE,
  output logic                               ERR,
  input  logic                               ERR_CLR,
  output logic [15:0]                        BCNT,
  input  logic                               CNT_CLR
);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                            awvalid_q, awvalid_d;
  logic                            bready_q, bready_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [15:0]                     bcnt_q, bcnt_d;
  logic [2:0]                      beat_q, beat_d;
  logic                            w_hs;
  logic                            err_set;
  logic                            bcnt_inc;

  assign w_hs = (state_q == W) && PIX_VALID && M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    err_set   = 1'b0;
    bcnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          awaddr_d  = {CMD_ADDR[C_M_AXI_ADDR_WIDTH-1:5], 5'b0};
          beat_d    = 3'd0;
          awvalid_d = 1'b1;
          state_d   = AW;
        end
      end
      AW: begin
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          state_d   = W;
        end
      end
      W: begin
        if (w_hs) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            bready_d = 1'b1;
            state_d  = B;
          end
        end
      end
      B: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          bcnt_inc = 1'b1;
          err_set  = (M_AXI_BRESP != 2'b00);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error outranks a simultaneous clear; a clear outranks an increment.
    if (err_set)      err_d = 1'b1;
    else if (ERR_CLR) err_d = 1'b0;
    else              err_d = err_q;

    if (CNT_CLR)       bcnt_d = 16'd0;
    else if (bcnt_inc) bcnt_d = bcnt_q + 16'd1;
    else               bcnt_d = bcnt_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      beat_q    <= 3'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign CMD_READY     = (state_q == IDLE);
  assign BUSY          = (state_q != IDLE);
  assign PIX_READY     = (state_q == W) && M_AXI_WREADY;
  assign M_AXI_WVALID  = (state_q == W) && PIX_VALID;
  assign M_AXI_WLAST   = (state_q == W) && (beat_q == 3'd7);
  assign M_AXI_WDATA   = PIX_DATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'd7;
  assign M_AXI_AWSIZE  = 3'd2;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign BCNT          = bcnt_q;

endmodule

// File: tb/tb_draw_wburst.sv
// Bench for draw_wburst: an AXI write slave and pixel source driven cycle by
// cycle, with AW and W beats checked against scoreboard queues.
module tb_draw_wburst;

  logic        ACLK;
  logic        ARESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [31:0] CMD_ADDR;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [31:0] PIX_DATA;
  logic [0:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [3:0]  M_AXI_AWCACHE;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        ERR_CLR;
  logic [15:0] BCNT;
  logic        CNT_CLR;

  int checks = 0;
  int errors = 0;
  logic [31:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [15:0] exp_bcnt = 16'd0;
  logic        exp_err = 1'b0;

  draw_wburst dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CLR(ERR_CLR), .BCNT(BCNT), .CNT_CLR(CNT_CLR)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Runs one burst as both pixel source and AXI slave; returns the loop
  // iteration of the B handshake, or -1 if aborted/timed out.
  task automatic do_burst(input logic [31:0] addr, input logic [31:0] base,
                          input int aw_delay, input bit wtoggle, input bit pgaps,
                          input logic [1:0] bresp, input bit clr_err, input bit clr_cnt,
                          input int abort_beats, output int b_iter);
    int  nbeats;
    bit  aw_done;
    bit  b_done;
    logic [32:0] exp_w;
    logic [53:0] exp_aw;
    logic [53:0] got_aw;
    aw_q.push_back({addr[31:5], 5'b0});
    for (int i = 0; i < 8; i++) w_q.push_back({(i == 7), base + 32'(i)});
    CMD_ADDR  = addr;
    CMD_VALID = 1'b1;
    @(negedge ACLK);
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_ready got %b want 1", CMD_READY);
    end
    @(posedge ACLK); #1;
    CMD_VALID = 1'b0;
    CMD_ADDR  = $urandom;
    b_iter  = -1;
    nbeats  = 0;
    aw_done = 1'b0;
    b_done  = 1'b0;
    for (int k = 0; k < 200 && !b_done; k++) begin
      M_AXI_AWREADY = !aw_done && (k >= aw_delay);
      M_AXI_WREADY  = wtoggle ? k[0] : 1'b1;
      PIX_VALID     = (nbeats < 8) && (pgaps ? (k % 3 != 2) : 1'b1);
      PIX_DATA      = base + 32'(nbeats);
      M_AXI_BVALID  = (nbeats == 8);
      M_AXI_BRESP   = (nbeats == 8) ? bresp : 2'b00;
      ERR_CLR       = clr_err && (nbeats == 8);
      CNT_CLR       = clr_cnt && (nbeats == 8);
      @(negedge ACLK);
      if (!aw_done) begin
        exp_aw = {1'b1, aw_q.size() > 0 ? aw_q[0] : 32'hDEAD_BEEF, 8'd7, 3'd2, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0};
        got_aw = {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                  M_AXI_AWCACHE, M_AXI_AWID, M_AXI_WVALID, PIX_READY};
        checks++;
        if (got_aw !== exp_aw) begin
          errors++;
          $display("[TB] FAIL aw_phase iter %0d got %h want %h", k, got_aw, exp_aw);
        end
        if (M_AXI_AWREADY && aw_q.size() > 0) begin
          void'(aw_q.pop_front());
          aw_done = 1'b1;
        end
      end else begin
        checks++;
        if ({M_AXI_WVALID, PIX_READY} !== {(nbeats < 8) && PIX_VALID, (nbeats < 8) && M_AXI_WREADY}) begin
          errors++;
          $display("[TB] FAIL w_gating iter %0d got wvalid=%b pix_ready=%b", k, M_AXI_WVALID, PIX_READY);
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          exp_w = (w_q.size() > 0) ? w_q.pop_front() : 33'h1_FFFF_FFFF;
          checks++;
          if ({M_AXI_WLAST, M_AXI_WDATA} !== exp_w || M_AXI_WSTRB !== 4'hF) begin
            errors++;
            $display("[TB] FAIL w_beat %0d got last=%b data=%h strb=%h want last=%b data=%h strb=f",
                     nbeats, M_AXI_WLAST, M_AXI_WDATA, M_AXI_WSTRB, exp_w[32], exp_w[31:0]);
          end
          nbeats++;
          if (abort_beats > 0 && nbeats == abort_beats) return;
        end
        if (M_AXI_BVALID) begin
          checks++;
          if (M_AXI_BREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bready got %b want 1", M_AXI_BREADY);
          end
          b_done = 1'b1;
          b_iter = k;
        end
      end
      @(posedge ACLK); #1;
    end
    M_AXI_AWREADY = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    ERR_CLR       = 1'b0;
    CNT_CLR       = 1'b0;
    PIX_VALID     = 1'b0;
    checks++;
    if (!b_done) begin
      errors++;
      $display("[TB] FAIL burst_timeout got %0d beats want 8", nbeats);
      return;
    end
    exp_bcnt = clr_cnt ? 16'd0 : exp_bcnt + 16'd1;
    exp_err  = (bresp != 2'b00) ? 1'b1 : (clr_err ? 1'b0 : exp_err);
    @(negedge ACLK);
    checks++;
    if ({DONE, BUSY, CMD_READY, ERR, BCNT} !== {1'b1, 1'b0, 1'b1, exp_err, exp_bcnt}) begin
      errors++;
      $display("[TB] FAIL completion got done=%b busy=%b cmd_ready=%b err=%b bcnt=%0d want 1 0 1 %b %0d",
               DONE, BUSY, CMD_READY, ERR, BCNT, exp_err, exp_bcnt);
    end
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checks++;
    if (DONE !== 1'b0 || aw_q.size() != 0 || w_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL done_pulse got done=%b aw_left=%0d w_left=%0d want 0 0 0", DONE, aw_q.size(), w_q.size());
    end
    @(posedge ACLK); #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, PIX_READY,
         BUSY, DONE, ERR, BCNT, CMD_READY} !== {1'b0, 32'h0, 7'b0, 16'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL %s got awv=%b awaddr=%h wv=%b wl=%b br=%b pr=%b busy=%b done=%b err=%b bcnt=%0d cr=%b want reset values",
               tag, M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
               PIX_READY, BUSY, DONE, ERR, BCNT, CMD_READY);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    CMD_VALID = 1'b0; CMD_ADDR = 32'h0; PIX_VALID = 1'b0; PIX_DATA = 32'h0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
    ERR_CLR = 1'b0; CNT_CLR = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_values("reset_state");
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_single();
    int b_iter;
    do_burst(32'h1000_0024, 32'h0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
    checks++;
    if (b_iter !== 9) begin
      errors++;
      $display("[TB] FAIL single_latency got b_iter=%0d want 9", b_iter);
    end
  endtask

  task automatic test_backpressure();
    int b_iter;
    do_burst(32'h2345_67FF, 32'hA5A5_0100, 5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 0, b_iter);
  endtask

  task automatic test_idle_pixels();
    PIX_VALID = 1'b1;
    PIX_DATA  = 32'hCAFE_F00D;
    M_AXI_WREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checks++;
      if ({PIX_READY, M_AXI_WVALID, M_AXI_AWVALID, BUSY} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL idle_pixels got pr=%b wv=%b awv=%b busy=%b want 0000",
                 PIX_READY, M_AXI_WVALID, M_AXI_AWVALID, BUSY);
      end
    end
    PIX_VALID = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_mid_reset();
    int b_iter;
    do_burst(32'h3000_0040, 32'h0000_0700, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4, b_iter);
    @(posedge ACLK); #2;
    PIX_VALID = 1'b1;
    ARESETN   = 1'b0;
    #1;
    check_reset_values("mid_burst_reset");
    aw_q.delete();
    w_q.delete();
    exp_bcnt = 16'd0;
    exp_err  = 1'b0;
    PIX_VALID = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    do_burst(32'h3000_0080, 32'h0000_0800, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
  endtask

  task automatic test_counter();
    int b_iter;
    CNT_CLR = 1'b1;
    @(posedge ACLK); #1;
    CNT_CLR = 1'b0;
    exp_bcnt = 16'd0;
    for (int i = 0; i < 3; i++)
      do_burst(32'h4000_0000 + 32'(i * 32), 32'h100 * 32'(i), 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
    checks++;
    if (BCNT !== 16'd3) begin
      errors++;
      $display("[TB] FAIL bcnt_three got %0d want 3", BCNT);
    end
    @(negedge ACLK);
    force dut.bcnt_q = 16'hFFFF;
    #1;
    release dut.bcnt_q;
    exp_bcnt = 16'hFFFF;
    @(posedge ACLK); #1;
    do_burst(32'h4000_1000, 32'h0000_0900, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
    do_burst(32'h4000_2000, 32'h0000_0A00, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
    do_burst(32'h4000_3000, 32'h0000_0B00, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 0, b_iter);
  endtask

  task automatic test_error();
    int b_iter;
    do_burst(32'h5000_0000, 32'h0000_0C00, 0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 0, b_iter);
    do_burst(32'h5000_0020, 32'h0000_0D00, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, b_iter);
    ERR_CLR = 1'b1;
    @(posedge ACLK); #1;
    ERR_CLR = 1'b0;
    exp_err = 1'b0;
    @(negedge ACLK);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got %b want 0", ERR);
    end
    @(posedge ACLK); #1;
    do_burst(32'h5000_0040, 32'h0000_0E00, 0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 0, b_iter);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_idle_pixels();
    test_mid_reset();
    test_counter();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
